// File: rtl/lcd_spi_init_sequencer_pkg.sv
// Shared definitions for the LCD 3-wire power-up configuration sequencer.
//   state_t        : sequencer state encoding
//   REG_*          : LCD panel register addresses used by the init table
//   make_word()    : packs {addr[5:0], 2'b00 (write), data[7:0]} into a serial word
//   cnt_width()    : width of a counter that must reach max(a,b,c)-1
package lcd_spi_init_sequencer_pkg;

    typedef enum logic [2:0] {
        S_PWRUP = 3'd0,
        S_LOAD  = 3'd1,
        S_SEND  = 3'd2,
        S_WAIT  = 3'd3,
        S_GAP   = 3'd4,
        S_DONE  = 3'd5,
        S_ERR   = 3'd6
    } state_t;

    localparam int WORD_W = 16;
    localparam int IDX_W  = 5;

    // Panel register map (6-bit addresses)
    localparam logic [5:0] REG_PWR_CTRL      = 6'h02;
    localparam logic [5:0] REG_DRV_CTRL      = 6'h03;
    localparam logic [5:0] REG_MODE          = 6'h04;
    localparam logic [5:0] REG_HSYNC_DLY     = 6'h05;
    localparam logic [5:0] REG_VSYNC_DLY     = 6'h06;
    localparam logic [5:0] REG_VCOM          = 6'h07;
    localparam logic [5:0] REG_CONTRAST      = 6'h08;
    localparam logic [5:0] REG_SUB_CONT_R    = 6'h09;
    localparam logic [5:0] REG_SUB_BRIGHT_R  = 6'h0A;
    localparam logic [5:0] REG_SUB_CONT_B    = 6'h0B;
    localparam logic [5:0] REG_SUB_BRIGHT_B  = 6'h0C;
    localparam logic [5:0] REG_TIMING        = 6'h0D;
    localparam logic [5:0] REG_GAMMA0        = 6'h10;
    localparam logic [5:0] REG_GAMMA1        = 6'h11;
    localparam logic [5:0] REG_GAMMA2        = 6'h12;
    localparam logic [5:0] REG_GAMMA3        = 6'h13;
    localparam logic [5:0] REG_GAMMA4        = 6'h14;
    localparam logic [5:0] REG_GAMMA5        = 6'h15;
    localparam logic [5:0] REG_GAMMA6        = 6'h16;
    localparam logic [5:0] REG_GAMMA7        = 6'h17;

    function automatic logic [WORD_W-1:0] make_word(input logic [5:0] addr,
                                                    input logic [7:0] data);
        return {addr, 2'b00, data};
    endfunction

    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/lcd_spi_init_sequencer_if.sv
// Start/ready handshake between the init sequencer and the 3-wire serial controller.
//   oSTR  : start level, high for the whole transfer (sequencer -> controller)
//   oDATA : 16-bit register word, stable while oSTR is high (sequencer -> controller)
//   iRDY  : transfer-complete level from the serial-clock domain (controller -> sequencer)
interface lcd_spi_init_sequencer_if;
    import lcd_spi_init_sequencer_pkg::*;

    logic              oSTR;
    logic [WORD_W-1:0] oDATA;
    logic              iRDY;

    modport master (output oSTR, output oDATA, input iRDY);
    modport slave  (input  oSTR, input  oDATA, output iRDY);

endinterface

// File: rtl/lcd_spi_init_sequencer_rom.sv
// Fixed panel initialisation table.
//   i_idx  : 5-bit table index
//   o_word : register word for that index; unused indices return 16'h0000
module lcd_spi_init_sequencer_rom
    import lcd_spi_init_sequencer_pkg::*;
(
    input  logic [IDX_W-1:0]  i_idx,
    output logic [WORD_W-1:0] o_word
);

    always_comb begin
        o_word = '0;
        case (i_idx)
            5'd0:    o_word = make_word(REG_PWR_CTRL,     8'h07);
            5'd1:    o_word = make_word(REG_DRV_CTRL,     8'h5F);
            5'd2:    o_word = make_word(REG_MODE,         8'h17);
            5'd3:    o_word = make_word(REG_HSYNC_DLY,    8'h20);
            5'd4:    o_word = make_word(REG_VSYNC_DLY,    8'h08);
            5'd5:    o_word = make_word(REG_VCOM,         8'h20);
            5'd6:    o_word = make_word(REG_CONTRAST,     8'h20);
            5'd7:    o_word = make_word(REG_SUB_CONT_R,   8'h20);
            5'd8:    o_word = make_word(REG_SUB_BRIGHT_R, 8'h27);
            5'd9:    o_word = make_word(REG_SUB_CONT_B,   8'h20);
            5'd10:   o_word = make_word(REG_SUB_BRIGHT_B, 8'h20);
            5'd11:   o_word = make_word(REG_TIMING,       8'h10);
            5'd12:   o_word = make_word(REG_GAMMA0,       8'h3F);
            5'd13:   o_word = make_word(REG_GAMMA1,       8'h3F);
            5'd14:   o_word = make_word(REG_GAMMA2,       8'h2F);
            5'd15:   o_word = make_word(REG_GAMMA3,       8'h2F);
            5'd16:   o_word = make_word(REG_GAMMA4,       8'h17);
            5'd17:   o_word = make_word(REG_GAMMA5,       8'h17);
            5'd18:   o_word = make_word(REG_GAMMA6,       8'h17);
            5'd19:   o_word = make_word(REG_GAMMA7,       8'h17);
            default: o_word = '0;
        endcase
    end

endmodule

// File: rtl/lcd_spi_init_sequencer.sv
// Power-up configuration sequencer for the LCD 3-wire serial register interface.
// Waits PWRUP_CYC after reset, then walks the init table, issuing each word with
// the controller's start/ready handshake, and reports completion or timeout.
//   iCLK     : system clock
//   iRST     : asynchronous active-low reset
//   iREINIT  : one-cycle pulse, replays the table from S_DONE or S_ERR only
//   bus      : master side of the start/data/ready handshake
//   oIDX     : index of the current or last word
//   oBUSY    : sequencing in progress (S_PWRUP..S_GAP)
//   oDONE    : table fully written; display datapath may start
//   oERR     : controller did not answer within TIMEOUT_CYC
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_PWRUP | panel power-up delay after reset
// S_LOAD  | fetch table word for oIDX into oDATA
// S_SEND  | raise oSTR
// S_WAIT  | transfer in flight, waiting for synchronised ready
// S_GAP   | oSTR low, minimum gap and wait for ready to drop
// S_DONE  | table complete, idle
// S_ERR   | ready timeout, idle with oIDX on the failing word
module lcd_spi_init_sequencer
    import lcd_spi_init_sequencer_pkg::*;
#(
    parameter int PWRUP_CYC   = 1_000_000,
    parameter int GAP_CYC     = 16_384,
    parameter int TIMEOUT_CYC = 500_000,
    parameter int LUT_SIZE    = 20
)(
    input  logic                       iCLK,
    input  logic                       iRST,
    input  logic                       iREINIT,
    lcd_spi_init_sequencer_if.master   bus,
    output logic [IDX_W-1:0]           oIDX,
    output logic                       oBUSY,
    output logic                       oDONE,
    output logic                       oERR
);

    localparam int CNT_W = cnt_width(PWRUP_CYC, GAP_CYC, TIMEOUT_CYC);

    localparam logic [CNT_W-1:0] PWRUP_LAST   = CNT_W'(PWRUP_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(GAP_CYC - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
    localparam logic [IDX_W-1:0] IDX_LAST     = IDX_W'(LUT_SIZE - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    w_cnt_nxt;
    logic                r_str;
    logic                w_str_nxt;
    logic [WORD_W-1:0]   r_data;
    logic [WORD_W-1:0]   w_data_nxt;
    logic [IDX_W-1:0]    r_idx;
    logic [IDX_W-1:0]    w_idx_nxt;
    logic [1:0]          r_rdy_sync;
    logic                w_rdy_s;
    logic [WORD_W-1:0]   w_rom_word;

    // iRDY comes from the serial-clock domain
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            r_rdy_sync <= 2'b00;
        end else begin
            r_rdy_sync <= {r_rdy_sync[0], bus.iRDY};
        end
    end

    assign w_rdy_s = r_rdy_sync[1];

    lcd_spi_init_sequencer_rom u_rom (
        .i_idx  (r_idx),
        .o_word (w_rom_word)
    );

    // oSTR is a register with async clear so a reset mid-transfer aborts the controller at once
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            r_state <= S_PWRUP;
            r_cnt   <= '0;
            r_str   <= 1'b0;
            r_data  <= '0;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_str   <= w_str_nxt;
            r_data  <= w_data_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_str_nxt   = r_str;
        w_data_nxt  = r_data;
        w_idx_nxt   = r_idx;

        case (r_state)
            S_PWRUP: begin
                if (r_cnt == PWRUP_LAST) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_LOAD;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end

            S_LOAD: begin
                w_data_nxt  = w_rom_word;
                w_state_nxt = S_SEND;
            end

            S_SEND: begin
                w_str_nxt   = 1'b1;
                w_cnt_nxt   = '0;
                w_state_nxt = S_WAIT;
            end

            S_WAIT: begin
                // ready is tested first so it wins over a coincident timeout
                if (w_rdy_s) begin
                    w_str_nxt   = 1'b0;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_GAP;
                end else if (r_cnt == TIMEOUT_LAST) begin
                    w_str_nxt   = 1'b0;
                    w_state_nxt = S_ERR;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end

            S_GAP: begin
                // counter parks at GAP_LAST while a slow controller still holds ready
                if (r_cnt == GAP_LAST) begin
                    if (!w_rdy_s) begin
                        w_cnt_nxt = '0;
                        if (r_idx == IDX_LAST) begin
                            w_state_nxt = S_DONE;
                        end else begin
                            w_idx_nxt   = r_idx + IDX_W'(1);
                            w_state_nxt = S_LOAD;
                        end
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end

            S_DONE, S_ERR: begin
                if (iREINIT) begin
                    w_idx_nxt   = '0;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_LOAD;
                end
            end

            default: begin
                w_str_nxt   = 1'b0;
                w_cnt_nxt   = '0;
                w_state_nxt = S_PWRUP;
            end
        endcase
    end

    assign bus.oSTR  = r_str;
    assign bus.oDATA = r_data;
    assign oIDX      = r_idx;
    assign oDONE     = (r_state == S_DONE);
    assign oERR      = (r_state == S_ERR);
    assign oBUSY     = !((r_state == S_DONE) || (r_state == S_ERR));

endmodule

// File: tb/tb_lcd_spi_init_sequencer.sv
module tb_lcd_spi_init_sequencer;

    localparam int PWRUP   = 10;
    localparam int GAP     = 8;
    localparam int TIMEOUT = 100;
    localparam int LUT     = 4;

    typedef struct {
        logic [4:0]  idx;
        logic [15:0] data;
    } exp_t;

    logic       iCLK;
    logic       iRST;
    logic       iREINIT;
    logic [4:0] oIDX;
    logic       oBUSY;
    logic       oDONE;
    logic       oERR;

    lcd_spi_init_sequencer_if bus ();

    lcd_spi_init_sequencer #(
        .PWRUP_CYC   (PWRUP),
        .GAP_CYC     (GAP),
        .TIMEOUT_CYC (TIMEOUT),
        .LUT_SIZE    (LUT)
    ) dut (
        .iCLK    (iCLK),
        .iRST    (iRST),
        .iREINIT (iREINIT),
        .bus     (bus.master),
        .oIDX    (oIDX),
        .oBUSY   (oBUSY),
        .oDONE   (oDONE),
        .oERR    (oERR)
    );

    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;
    exp_t exp_q[$];

    int   rise_count = 0;
    int   last_rise  = 0;
    int   last_fall  = 0;

    int   no_rdy_idx   = -1;
    bit   pulse_mode   = 0;
    int   hold_extra   = 0;
    int   rdy_fall_cyc = 0;

    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    initial forever begin
        @(posedge iCLK);
        cyc = cyc + 1;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
        $fatal(1);
    end

    function automatic logic [15:0] ref_word(input int i);
        logic [15:0] w;
        case (i)
            0:       w = 16'h0807;
            1:       w = 16'h0C5F;
            2:       w = 16'h1017;
            3:       w = 16'h1420;
            default: w = 16'h0000;
        endcase
        return w;
    endfunction

    task automatic push_words(input int first, input int last);
        exp_t e;
        for (int i = first; i <= last; i++) begin
            e.idx  = 5'(i);
            e.data = ref_word(i);
            exp_q.push_back(e);
        end
    endtask

    task automatic pulse_reinit(output int c);
        @(negedge iCLK);
        c = cyc;
        iREINIT = 1'b1;
        @(negedge iCLK);
        iREINIT = 1'b0;
    endtask

    // Controller model: ready 20 cycles after start, dropped one cycle after start falls
    initial begin
        int hi_cnt;
        int lo_cnt;
        hi_cnt = 0;
        lo_cnt = 0;
        bus.iRDY = 1'b0;
        forever begin
            @(negedge iCLK);
            if (!iRST) begin
                bus.iRDY = 1'b0;
                hi_cnt = 0;
                lo_cnt = 0;
            end else if (bus.oSTR) begin
                lo_cnt = 0;
                hi_cnt = hi_cnt + 1;
                if (hi_cnt == 20 && int'(oIDX) != no_rdy_idx) begin
                    bus.iRDY = 1'b1;
                end else if (pulse_mode && hi_cnt == 21 && bus.iRDY) begin
                    bus.iRDY = 1'b0;
                    rdy_fall_cyc = cyc;
                end
            end else begin
                hi_cnt = 0;
                if (bus.iRDY) begin
                    lo_cnt = lo_cnt + 1;
                    if (lo_cnt > hold_extra) begin
                        bus.iRDY = 1'b0;
                        rdy_fall_cyc = cyc;
                        lo_cnt = 0;
                    end
                end
            end
        end
    end

    // Scoreboard: each start pops one expected word
    initial begin
        logic        prev_str;
        logic [15:0] rise_data;
        exp_t        e;
        prev_str  = 1'b0;
        rise_data = '0;
        forever begin
            @(negedge iCLK);
            if (bus.oSTR === 1'b1 && prev_str === 1'b0) begin
                rise_count = rise_count + 1;
                last_rise  = cyc;
                rise_data  = bus.oDATA;
                n_cmp = n_cmp + 1;
                if (exp_q.size() == 0) begin
                    n_err = n_err + 1;
                    $display("FAIL unexpected_str: oIDX=%0d oDATA=%h at cycle %0d, required no transfer",
                             oIDX, bus.oDATA, cyc);
                end else begin
                    e = exp_q.pop_front();
                    n_cmp = n_cmp + 1;
                    if (bus.oDATA !== e.data) begin
                        n_err = n_err + 1;
                        $display("FAIL word_data: got %h, required %h (idx %0d)", bus.oDATA, e.data, e.idx);
                    end
                    n_cmp = n_cmp + 1;
                    if (oIDX !== e.idx) begin
                        n_err = n_err + 1;
                        $display("FAIL word_idx: got %0d, required %0d", oIDX, e.idx);
                    end
                end
            end else if (bus.oSTR === 1'b0 && prev_str === 1'b1) begin
                last_fall = cyc;
                if (iRST) begin
                    n_cmp = n_cmp + 1;
                    if (bus.oDATA !== rise_data) begin
                        n_err = n_err + 1;
                        $display("FAIL data_hold: got %h at fall, required %h", bus.oDATA, rise_data);
                    end
                end
            end
            prev_str = bus.oSTR;
        end
    end

    task automatic test_reset();
        iRST    = 1'b0;
        iREINIT = 1'b0;
        repeat (3) @(negedge iCLK);
        n_cmp++; if (bus.oSTR !== 1'b0)      begin n_err++; $display("FAIL reset_str: got %b, required 0", bus.oSTR); end
        n_cmp++; if (bus.oDATA !== 16'h0000) begin n_err++; $display("FAIL reset_data: got %h, required 0000", bus.oDATA); end
        n_cmp++; if (oIDX !== 5'd0)          begin n_err++; $display("FAIL reset_idx: got %0d, required 0", oIDX); end
        n_cmp++; if (oBUSY !== 1'b1)         begin n_err++; $display("FAIL reset_busy: got %b, required 1", oBUSY); end
        n_cmp++; if (oDONE !== 1'b0)         begin n_err++; $display("FAIL reset_done: got %b, required 0", oDONE); end
        n_cmp++; if (oERR !== 1'b0)          begin n_err++; $display("FAIL reset_err: got %b, required 0", oERR); end
    endtask

    task automatic test_powerup();
        int c, n, r0, f0;
        push_words(0, LUT - 1);
        c = cyc;
        iRST = 1'b1;
        n = 0;
        while (rise_count < 1 && n < 100) begin @(negedge iCLK); n++; end
        n_cmp++; if (last_rise - c != PWRUP + 2) begin n_err++; $display("FAIL pwrup_first_str: got %0d cycles, required %0d", last_rise - c, PWRUP + 2); end
        r0 = last_rise;
        n = 0;
        while (bus.oSTR && n < 200) begin @(negedge iCLK); n++; end
        f0 = last_fall;
        n_cmp++; if (f0 - r0 != 22) begin n_err++; $display("FAIL str_width: got %0d cycles, required 22", f0 - r0); end
        n = 0;
        while (rise_count < 2 && n < 200) begin @(negedge iCLK); n++; end
        n_cmp++; if (last_rise - f0 != GAP + 2) begin n_err++; $display("FAIL gap_len: got %0d cycles, required %0d", last_rise - f0, GAP + 2); end
        n = 0;
        while (!oDONE && n < 2000) begin @(negedge iCLK); n++; end
        n_cmp++; if (oDONE !== 1'b1) begin n_err++; $display("FAIL pwrup_done: got %b, required 1", oDONE); end
        n_cmp++; if (oBUSY !== 1'b0) begin n_err++; $display("FAIL pwrup_busy: got %b, required 0", oBUSY); end
        n_cmp++; if (rise_count != LUT) begin n_err++; $display("FAIL pwrup_count: got %0d words, required %0d", rise_count, LUT); end
        n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL pwrup_pending: got %0d left, required 0", exp_q.size()); end
    endtask

    task automatic test_timeout();
        int c, n, base;
        no_rdy_idx = 2;
        push_words(0, 2);
        pulse_reinit(c);
        n = 0;
        while (!oERR && n < 1000) begin @(negedge iCLK); n++; end
        n_cmp++; if (oERR !== 1'b1) begin n_err++; $display("FAIL timeout_err: got %b, required 1", oERR); end
        n_cmp++; if (last_fall - last_rise != TIMEOUT) begin n_err++; $display("FAIL timeout_len: got %0d cycles, required %0d", last_fall - last_rise, TIMEOUT); end
        n_cmp++; if (oIDX !== 5'd2) begin n_err++; $display("FAIL timeout_idx: got %0d, required 2", oIDX); end
        n_cmp++; if (oDONE !== 1'b0 || oBUSY !== 1'b0) begin n_err++; $display("FAIL timeout_flags: got done=%b busy=%b, required 0 0", oDONE, oBUSY); end
        base = rise_count;
        repeat (50) @(negedge iCLK);
        n_cmp++; if (rise_count != base || bus.oSTR !== 1'b0) begin n_err++; $display("FAIL timeout_quiet: got %0d extra starts, required 0", rise_count - base); end
        no_rdy_idx = -1;
    endtask

    task automatic test_reinit_from_err();
        int c, n, base;
        base = rise_count;
        push_words(0, LUT - 1);
        pulse_reinit(c);
        n = 0;
        while (rise_count == base && n < 50) begin @(negedge iCLK); n++; end
        n_cmp++; if (last_rise - (c + 1) != 2) begin n_err++; $display("FAIL reinit_latency: got %0d cycles, required 2", last_rise - (c + 1)); end
        n = 0;
        while (!oDONE && n < 2000) begin @(negedge iCLK); n++; end
        n_cmp++; if (oDONE !== 1'b1 || oERR !== 1'b0) begin n_err++; $display("FAIL reinit_done: got done=%b err=%b, required 1 0", oDONE, oERR); end
        n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL reinit_pending: got %0d left, required 0", exp_q.size()); end
    endtask

    task automatic test_gap_extend();
        int c, n, base;
        hold_extra = 30;
        base = rise_count;
        push_words(0, LUT - 1);
        pulse_reinit(c);
        n = 0;
        while (rise_count < base + 2 && n < 400) begin @(negedge iCLK); n++; end
        n_cmp++; if (last_rise - rdy_fall_cyc < 3) begin n_err++; $display("FAIL gap_after_rdy: got %0d cycles, required >= 3", last_rise - rdy_fall_cyc); end
        n_cmp++; if (last_rise - last_fall <= 30) begin n_err++; $display("FAIL gap_extended: got %0d cycles, required > 30", last_rise - last_fall); end
        n = 0;
        while (!oDONE && n < 3000) begin @(negedge iCLK); n++; end
        n_cmp++; if (oDONE !== 1'b1 || exp_q.size() != 0) begin n_err++; $display("FAIL gap_done: got done=%b pending=%0d, required 1 0", oDONE, exp_q.size()); end
        hold_extra = 0;
        repeat (40) @(negedge iCLK);
    endtask

    task automatic test_reset_mid();
        int c, n, base;
        push_words(0, 1);
        pulse_reinit(c);
        n = 0;
        while (!(bus.oSTR && oIDX == 5'd1) && n < 300) begin @(negedge iCLK); n++; end
        n_cmp++; if (!(bus.oSTR && oIDX == 5'd1)) begin n_err++; $display("FAIL rst_mid_reach: got str=%b idx=%0d, required 1 1", bus.oSTR, oIDX); end
        #1;
        iRST = 1'b0;
        #1;
        n_cmp++; if (bus.oSTR !== 1'b0) begin n_err++; $display("FAIL rst_mid_str: got %b, required 0", bus.oSTR); end
        n_cmp++; if (oIDX !== 5'd0)     begin n_err++; $display("FAIL rst_mid_idx: got %0d, required 0", oIDX); end
        exp_q.delete();
        repeat (3) @(negedge iCLK);
        base = rise_count;
        push_words(0, LUT - 1);
        c = cyc;
        iRST = 1'b1;
        n = 0;
        while (rise_count == base && n < 100) begin @(negedge iCLK); n++; end
        n_cmp++; if (last_rise - c != PWRUP + 2) begin n_err++; $display("FAIL rst_mid_restart: got %0d cycles, required %0d", last_rise - c, PWRUP + 2); end
        n = 0;
        while (!oDONE && n < 2000) begin @(negedge iCLK); n++; end
        n_cmp++; if (oDONE !== 1'b1 || exp_q.size() != 0) begin n_err++; $display("FAIL rst_mid_done: got done=%b pending=%0d, required 1 0", oDONE, exp_q.size()); end
    endtask

    task automatic test_reinit_in_wait();
        int c, n, s;
        pulse_mode = 1;
        push_words(0, LUT - 1);
        pulse_reinit(c);
        n = 0;
        while (!(bus.oSTR && oIDX == 5'd1) && n < 300) begin @(negedge iCLK); n++; end
        s = last_rise;
        pulse_reinit(c);
        n_cmp++; if (oIDX !== 5'd1 || bus.oSTR !== 1'b1) begin n_err++; $display("FAIL wait_reinit_ignored: got idx=%0d str=%b, required 1 1", oIDX, bus.oSTR); end
        n = 0;
        while (bus.oSTR && n < 200) begin @(negedge iCLK); n++; end
        n_cmp++; if (last_fall - s != 22) begin n_err++; $display("FAIL pulse_rdy_accept: got %0d cycles, required 22", last_fall - s); end
        n = 0;
        while (!oDONE && n < 2000) begin @(negedge iCLK); n++; end
        n_cmp++; if (oDONE !== 1'b1 || exp_q.size() != 0) begin n_err++; $display("FAIL pulse_done: got done=%b pending=%0d, required 1 0", oDONE, exp_q.size()); end
        pulse_mode = 0;
    endtask

    initial begin
        test_reset();
        test_powerup();
        test_timeout();
        test_reinit_from_err();
        test_gap_extend();
        test_reset_mid();
        test_reinit_in_wait();
        repeat (5) @(negedge iCLK);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
